// File: rtl/h264_pack_pkg.sv
// Shared types and helpers for the H.264 byte packer: the FIFO word format,
// the packer hold-state encoding and the partial-word keep mask.
package h264_pack_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } pack_word_t;

  typedef enum logic {
    PK_ACC,
    PK_HOLD
  } pk_state_e;

  // Contiguous-from-bit-0 byte mask for a partial word of cnt bytes.
  function automatic logic [3:0] keep_from_cnt(input logic [CNT_W-1:0] cnt);
    logic [3:0] keep;
    case (cnt)
      2'd0:    keep = 4'h0;
      2'd1:    keep = 4'h1;
      2'd2:    keep = 4'h3;
      default: keep = 4'h7;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/h264_word_fifo.sv
// Synchronous word FIFO with a registered first-word-fall-through output stage.
// The output register counts toward the level, so total capacity is DEPTH words.
module h264_word_fifo
  import h264_pack_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  pack_word_t         push_word,
  input  logic               pop_ready,
  output pack_word_t         out_word,
  output logic               out_valid,
  output logic               full,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  pack_word_t         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] mem_cnt;
  logic               pop;
  logic               wr_en;
  logic               ld;

  assign level = mem_cnt + LEVEL_W'(out_valid);
  assign full  = (level == LEVEL_W'(DEPTH));
  assign pop   = out_valid && pop_ready;
  // A pop frees a slot this same edge, so a push at full is still accepted.
  assign wr_en = push && (!full || pop);
  assign ld    = (mem_cnt != '0) && (!out_valid || pop);

  // NOTE: storage is deliberately left out of reset; the pointers and counts
  // define which entries are meaningful, and resetting an array blocks RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (ld)    rd_ptr <= rd_ptr + PTR_W'(1);

      case ({wr_en, ld})
        2'b10:   mem_cnt <= mem_cnt + LEVEL_W'(1);
        2'b01:   mem_cnt <= mem_cnt - LEVEL_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase

      if (ld) begin
        out_word  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/h264_byte_packer.sv
// Packs the encoder byte stream into 32-bit little-endian AXI4-Stream words.
// Optional per-NAL byte count output enabled by H264_PACK_NALCOUNT_EN.
module h264_byte_packer
  import h264_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [7:0]         BYTE,
  input  logic               STROBE,
  input  logic               DONE,
  output logic [31:0]        M_AXIS_TDATA,
  output logic [3:0]         M_AXIS_TKEEP,
  output logic               M_AXIS_TLAST,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic               OVERFLOW,
  output logic [LEVEL_W-1:0] FIFO_LEVEL
`ifdef H264_PACK_NALCOUNT_EN
  ,
  output logic [23:0]        NAL_BYTES,
  output logic               NAL_BYTES_VLD
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

  pk_state_e        state, state_d;
  logic [31:0]      acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      hold_data, hold_data_d;
  logic             done_pend, done_pend_d;

  logic             push;
  pack_word_t       push_word;
  pack_word_t       out_word;
  logic             fifo_full;
  logic             pop;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    cnt_d       = cnt;
    hold_data_d = hold_data;
    done_pend_d = DONE;
    push        = 1'b0;
    push_word   = '0;

    if (done_pend) begin
      // Close cycle: a partial word and a held word are mutually exclusive.
      if (cnt != '0) begin
        push      = 1'b1;
        push_word = '{data: acc, keep: keep_from_cnt(cnt), last: 1'b1};
      end else if (state == PK_HOLD) begin
        push      = 1'b1;
        push_word = '{data: hold_data, keep: 4'hF, last: 1'b1};
      end
      state_d = PK_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      if (STROBE) begin
        acc_d[7:0] = BYTE;
        cnt_d      = CNT_W'(1);
      end
    end else if (STROBE) begin
      if (state == PK_HOLD) begin
        push      = 1'b1;
        push_word = '{data: hold_data, keep: 4'hF, last: 1'b0};
        state_d   = PK_ACC;
      end
      acc_d[{cnt, 3'b000} +: 8] = BYTE;
      if (cnt == CNT_LAST) begin
        hold_data_d = acc_d;
        state_d     = PK_HOLD;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= PK_ACC;
      acc       <= '0;
      cnt       <= '0;
      hold_data <= '0;
      done_pend <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      hold_data <= hold_data_d;
      done_pend <= done_pend_d;
    end
  end

  h264_word_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETN),
    .push      (push),
    .push_word (push_word),
    .pop_ready (M_AXIS_TREADY),
    .out_word  (out_word),
    .out_valid (M_AXIS_TVALID),
    .full      (fifo_full),
    .level     (FIFO_LEVEL)
  );

  assign M_AXIS_TDATA = out_word.data;
  assign M_AXIS_TKEEP = out_word.keep;
  assign M_AXIS_TLAST = out_word.last;
  assign pop          = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      OVERFLOW <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      OVERFLOW <= 1'b1;
    end
  end

`ifdef H264_PACK_NALCOUNT_EN
  logic [23:0] nal_cnt;

  // A byte arriving in the close cycle belongs to the next NAL.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      nal_cnt       <= '0;
      NAL_BYTES     <= '0;
      NAL_BYTES_VLD <= 1'b0;
    end else begin
      NAL_BYTES_VLD <= done_pend;
      if (done_pend) begin
        NAL_BYTES <= nal_cnt;
        nal_cnt   <= STROBE ? 24'd1 : 24'd0;
      end else if (STROBE && (nal_cnt != 24'hFFFFFF)) begin
        nal_cnt <= nal_cnt + 24'd1;
      end
    end
  end
`else
  // Byte counting is compiled out; no extra ports or state exist.
`endif

endmodule

// File: tb/tb_h264_byte_packer.sv
// Directed self-checking bench for h264_byte_packer (default build, FIFO_DEPTH=16).
module tb_h264_byte_packer;
  import h264_pack_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [7:0]    BYTE;
  logic          STROBE;
  logic          DONE;
  logic [31:0]   M_AXIS_TDATA;
  logic [3:0]    M_AXIS_TKEEP;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic          OVERFLOW;
  logic [LW-1:0] FIFO_LEVEL;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  h264_byte_packer #(
    .FIFO_DEPTH (DEPTH),
    .LEVEL_W    (LW)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .BYTE          (BYTE),
    .STROBE        (STROBE),
    .DONE          (DONE),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .OVERFLOW      (OVERFLOW),
    .FIFO_LEVEL    (FIFO_LEVEL)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of input: applied at the falling edge, sampled by the next rising edge.
  task automatic step(input logic s, input logic [7:0] b, input logic d);
    @(negedge CLK);
    STROBE = s;
    BYTE   = b;
    DONE   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(M_AXIS_TVALID), 32'd0);
    check({tag, "_tlast"},  32'(M_AXIS_TLAST),  32'd0);
    check({tag, "_tkeep"},  32'(M_AXIS_TKEEP),  32'd0);
    check({tag, "_tdata"},  M_AXIS_TDATA,       32'd0);
    check({tag, "_ovf"},    32'(OVERFLOW),      32'd0);
    check({tag, "_level"},  32'(FIFO_LEVEL),    32'd0);
  endtask

  // Waits (bounded) for a beat, checks it, then accepts it with a one-cycle TREADY.
  task automatic expect_beat(input string tag, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
    int waited = 0;
    while (!M_AXIS_TVALID && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, "_tvalid"}, 32'(M_AXIS_TVALID), 32'd1);
    if (M_AXIS_TVALID) begin
      check({tag, "_tdata"}, M_AXIS_TDATA,       d);
      check({tag, "_tkeep"}, 32'(M_AXIS_TKEEP), 32'(k));
      check({tag, "_tlast"}, 32'(M_AXIS_TLAST), 32'(l));
      M_AXIS_TREADY = 1'b1;
      @(negedge CLK);
      M_AXIS_TREADY = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] w;

    RESETN        = 1'b0;
    BYTE          = 8'h00;
    STROBE        = 1'b0;
    DONE          = 1'b0;
    M_AXIS_TREADY = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    RESETN = 1'b1;
    idle(2);

    // Two full words, DONE on the eighth byte
    for (int i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h08, 1'b1);
    idle(4);
    check("two_words_level", 32'(FIFO_LEVEL), 32'd2);
    expect_beat("w0", 32'h04030201, 4'hF, 1'b0);
    expect_beat("w1", 32'h08070605, 4'hF, 1'b1);
    check("two_words_empty", 32'(M_AXIS_TVALID), 32'd0);

    // Partial word closed two cycles after the last byte; latency from DONE is 3
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    idle(1);
    check("lat_c1", 32'(M_AXIS_TVALID), 32'd0);
    idle(1);
    check("lat_c2", 32'(M_AXIS_TVALID), 32'd0);
    idle(1);
    check("lat_c3", 32'(M_AXIS_TVALID), 32'd1);
    expect_beat("part", 32'h00CCBBAA, 4'h7, 1'b1);

    // DONE with byte 05, new NAL byte 11 in the close cycle
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h05, 1'b1);
    step(1'b1, 8'h11, 1'b0);
    idle(1);
    step(1'b0, 8'h00, 1'b1);
    idle(4);
    check("coinc_level", 32'(FIFO_LEVEL), 32'd3);
    expect_beat("coinc_w0", 32'h04030201, 4'hF, 1'b0);
    expect_beat("coinc_w1", 32'h00000005, 4'h1, 1'b1);
    expect_beat("coinc_w2", 32'h00000011, 4'h1, 1'b1);

    // Empty NAL: no beat, no overflow
    step(1'b0, 8'h00, 1'b1);
    idle(5);
    check("empty_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("empty_level",  32'(FIFO_LEVEL),    32'd0);
    check("empty_ovf",    32'(OVERFLOW),      32'd0);

    // 17 words into a 16-deep FIFO with TREADY low; the closing 17th is dropped
    for (int i = 0; i < 68; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    idle(4);
    check("ovf_level", 32'(FIFO_LEVEL), 32'd16);
    check("ovf_flag",  32'(OVERFLOW),   32'd1);
    for (int wi = 0; wi < 16; wi++) begin
      w = {8'(4*wi+3), 8'(4*wi+2), 8'(4*wi+1), 8'(4*wi)};
      expect_beat($sformatf("ovf_w%0d", wi), w, 4'hF, 1'b0);
    end
    check("ovf_drained",  32'(M_AXIS_TVALID), 32'd0);
    check("ovf_sticky",   32'(OVERFLOW),      32'd1);

    // Reset mid-word discards partial data and clears OVERFLOW
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    RESETN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(2);
    RESETN = 1'b1;
    idle(1);
    for (int i = 8'h33; i <= 8'h36; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    idle(1);
    expect_beat("post_rst", 32'h36353433, 4'hF, 1'b1);
    idle(3);
    check("post_rst_empty", 32'(M_AXIS_TVALID), 32'd0);
    check("post_rst_ovf",   32'(OVERFLOW),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
